// File: rtl/uart_xmtr_stim.sv
// UART transmitter stimulus block: a small byte FIFO feeding an async serializer
// (start, LSB-first data, optional parity, stop) clocked at OVERSAMPLE x baud.
module uart_xmtr_stim #(
    parameter int OVERSAMPLE = 16,
    parameter int DEPTH      = 4,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     uart_sout,
    output logic                     tx_busy,
    output logic                     tx_done,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW         = $clog2(DEPTH);
    localparam int LW         = AW + 1;
    localparam bit HAS_PAR    = (PARITY == 1) || (PARITY == 2);
    localparam bit ODD_PAR    = (PARITY == 2);
    localparam int STOP_TICKS = STOP_BITS * OVERSAMPLE;
    localparam int TW         = $clog2(STOP_TICKS);

    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
    localparam logic [TW-1:0] DONE_AT   = TW'(STOP_TICKS - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    head;
    logic          push;
    logic          pop;

    assign tx_ready = (fifo_level != LW'(DEPTH));
    assign push     = tx_valid && tx_ready;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Serializer
    state_t        state, state_n;
    logic [TW-1:0] tick, tick_n, tick_inc;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          par_bit, par_n;
    logic          sout_n;
    logic          done_n;
    logic          busy_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            tick      <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            uart_sout <= 1'b1;
            tx_done   <= 1'b0;
            tx_busy   <= 1'b0;
        end else begin
            state     <= state_n;
            tick      <= tick_n;
            bit_idx   <= bit_n;
            shift     <= shift_n;
            par_bit   <= par_n;
            uart_sout <= sout_n;
            tx_done   <= done_n;
            tx_busy   <= busy_n;
        end
    end

    // uart_sout is registered, so each branch loads the level of the bit that
    // the *next* state drives rather than decoding it from the current state.
    always_comb begin
        state_n  = state;
        tick_n   = tick;
        bit_n    = bit_idx;
        shift_n  = shift;
        par_n    = par_bit;
        sout_n   = uart_sout;
        done_n   = 1'b0;
        pop      = 1'b0;
        tick_inc = tick + TW'(1);

        case (state)
            S_IDLE: begin
                sout_n = 1'b1;
                if (fifo_level != '0) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (tick == BIT_LAST) begin
                    state_n = S_DATA;
                    tick_n  = '0;
                    bit_n   = '0;
                    sout_n  = shift[0];
                end else begin
                    tick_n = tick_inc;
                end
            end
            S_DATA: begin
                if (tick == BIT_LAST) begin
                    tick_n = '0;
                    if (bit_idx == 3'd7) begin
                        if (HAS_PAR) begin
                            state_n = S_PARITY;
                            sout_n  = par_bit;
                        end else begin
                            state_n = S_STOP;
                            sout_n  = 1'b1;
                        end
                    end else begin
                        shift_n = {1'b0, shift[7:1]};
                        bit_n   = bit_idx + 3'd1;
                        sout_n  = shift[1];
                    end
                end else begin
                    tick_n = tick_inc;
                end
            end
            S_PARITY: begin
                if (tick == BIT_LAST) begin
                    state_n = S_STOP;
                    tick_n  = '0;
                    sout_n  = 1'b1;
                end else begin
                    tick_n = tick_inc;
                end
            end
            S_STOP: begin
                if (tick == DONE_AT) begin
                    done_n = 1'b1;
                end
                if (tick == STOP_LAST) begin
                    tick_n = '0;
                    if (fifo_level != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        sout_n  = 1'b1;
                    end
                end else begin
                    tick_n = tick_inc;
                end
            end
            default: begin
                state_n = S_IDLE;
                tick_n  = '0;
                sout_n  = 1'b1;
            end
        endcase

        if (pop) begin
            state_n = S_START;
            tick_n  = '0;
            shift_n = head;
            par_n   = (^head) ^ ODD_PAR;
            sout_n  = 1'b0;
        end

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_uart_xmtr_stim.sv
// Scoreboard bench for uart_xmtr_stim: pushed bytes queue expected frames, a
// per-instance line monitor decodes uart_sout and compares against the queue.
module tb_uart_xmtr_stim;

    localparam int PAR_T [4] = '{0, 1, 2, 0};
    localparam int SB_T  [4] = '{1, 1, 1, 2};

    logic       clk;
    logic       rst;
    logic [7:0] tx_data  [4];
    logic       tx_valid [4];
    logic       tx_ready [4];
    logic       sout     [4];
    logic       busy     [4];
    logic       done     [4];
    logic [2:0] level    [4];

    logic [7:0] exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic goto(input time t);
        if (t > $time) #(t - $time);
    endtask

    // Waits (bounded) for tx_ready at a negedge; accept happens on the following posedge.
    task automatic push(input int g, input logic [7:0] d, input bit keep, output time ta);
        @(negedge clk);
        tx_data[g]  = d;
        tx_valid[g] = 1'b1;
        for (int k = 0; k < 3000 && !tx_ready[g]; k++) @(negedge clk);
        check("push_ready", longint'(tx_ready[g]), 1);
        if (tx_ready[g]) exp_q.push_back(d);
        @(posedge clk);
        ta = $time;
        #1;
        if (!keep) tx_valid[g] = 1'b0;
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int PAR   = PAR_T[g];
        localparam int SB    = SB_T[g];
        localparam int NBITS = 9 + ((PAR == 1 || PAR == 2) ? 1 : 0) + SB;

        uart_xmtr_stim #(
            .OVERSAMPLE(16),
            .DEPTH(4),
            .PARITY(PAR),
            .STOP_BITS(SB)
        ) dut (
            .clock(clk),
            .reset(rst),
            .tx_data(tx_data[g]),
            .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]),
            .uart_sout(sout[g]),
            .tx_busy(busy[g]),
            .tx_done(done[g]),
            .fifo_level(level[g])
        );

        initial begin : mon
            logic [11:0] bits;
            logic [11:0] efr;
            logic [7:0]  eb;
            logic        aborted;
            forever begin
                @(negedge clk);
                if (!rst && sout[g] === 1'b0) begin
                    aborted = 1'b0;
                    bits    = '0;
                    for (int b = 0; b < NBITS; b++) begin
                        for (int k = 0; k < ((b == 0) ? 7 : 16); k++) begin
                            @(negedge clk);
                            if (rst) aborted = 1'b1;
                        end
                        bits[b] = sout[g];
                    end
                    if (!aborted) begin
                        check("frame_expected", longint'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            eb       = exp_q.pop_front();
                            efr      = '0;
                            efr[8:1] = eb;
                            if (PAR == 1) efr[9] = ^eb;
                            if (PAR == 2) efr[9] = ~^eb;
                            for (int s = NBITS - SB; s < NBITS; s++) efr[s] = 1'b1;
                            check("frame_data", longint'(bits[8:1]), longint'(eb));
                            check("frame_bits", longint'(bits), longint'(efr));
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        time ta, tb;
        time t4 [6];
        logic [7:0] b4 [6];
        b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33;
        b4[3] = 8'h44; b4[4] = 8'h5A; b4[5] = 8'hC3;

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data[i]  = '0;
            tx_valid[i] = 1'b0;
        end
        #22 rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_sout",  longint'(sout[0]),  1);
        check("rst_busy",  longint'(busy[0]),  0);
        check("rst_done",  longint'(done[0]),  0);
        check("rst_level", longint'(level[0]), 0);
        check("rst_ready", longint'(tx_ready[0]), 1);

        // 1: single 0x55 frame
        push(0, 8'h55, 1'b0, ta);
        goto(ta + 5);
        check("t1_sout_pre",  longint'(sout[0]),  1);
        check("t1_level_pre", longint'(level[0]), 1);
        goto(ta + 15);
        check("t1_sout_start", longint'(sout[0]),  0);
        check("t1_busy",       longint'(busy[0]),  1);
        check("t1_level_pop",  longint'(level[0]), 0);
        goto(ta + 1595);
        check("t1_done_early", longint'(done[0]), 0);
        goto(ta + 1605);
        check("t1_done",       longint'(done[0]), 1);
        goto(ta + 1615);
        check("t1_done_clear", longint'(done[0]), 0);
        check("t1_busy_clear", longint'(busy[0]), 0);
        check("t1_sout_idle",  longint'(sout[0]), 1);

        // 2: even then odd parity, 176-clock frame
        push(1, 8'h07, 1'b0, ta);
        goto(ta + 1755);
        check("t2e_done_early", longint'(done[1]), 0);
        goto(ta + 1765);
        check("t2e_done", longint'(done[1]), 1);
        goto(ta + 1800);
        push(2, 8'h07, 1'b0, ta);
        goto(ta + 1765);
        check("t2o_done", longint'(done[2]), 1);
        goto(ta + 1800);

        // 3: back-to-back frames with simultaneous push/pop
        push(0, 8'hA5, 1'b0, ta);
        push(0, 8'h3C, 1'b0, tb);
        check("t3_push_gap", longint'(tb - ta), 10);
        goto(ta + 15);
        check("t3_level_after_pushpop", longint'(level[0]), 1);
        goto(ta + 1605);
        check("t3_done1",      longint'(done[0]),  1);
        check("t3_sout_stop",  longint'(sout[0]),  1);
        check("t3_level_hold", longint'(level[0]), 1);
        goto(ta + 1615);
        check("t3_sout_start2", longint'(sout[0]),  0);
        check("t3_level_pop2",  longint'(level[0]), 0);
        check("t3_busy_cont",   longint'(busy[0]),  1);
        goto(ta + 3205);
        check("t3_done2", longint'(done[0]), 1);
        goto(ta + 3300);

        // 4: six bytes with tx_valid held high
        for (int i = 0; i < 5; i++) push(0, b4[i], 1'b1, t4[i]);
        goto(t4[4] + 5);
        check("t4_level_full", longint'(level[0]),    4);
        check("t4_ready_full", longint'(tx_ready[0]), 0);
        push(0, b4[5], 1'b0, t4[5]);
        check("t4_t1",  longint'(t4[1] - t4[0]), 10);
        check("t4_t4",  longint'(t4[4] - t4[0]), 40);
        check("t4_t5",  longint'(t4[5] - t4[0]), 1620);
        goto(t4[0] + 9700);
        check("t4_drained", longint'(exp_q.size()), 0);
        check("t4_idle",    longint'(busy[0]),      0);

        // 5: two stop bits
        push(3, 8'hFF, 1'b0, ta);
        goto(ta + 1605);
        check("t5_sout_stop2", longint'(sout[3]), 1);
        check("t5_busy_stop2", longint'(busy[3]), 1);
        goto(ta + 1755);
        check("t5_done_early", longint'(done[3]), 0);
        goto(ta + 1765);
        check("t5_done", longint'(done[3]), 1);
        goto(ta + 1775);
        check("t5_busy_clear", longint'(busy[3]), 0);
        goto(ta + 1800);

        // 6: reset mid-frame, then a clean frame
        push(0, 8'h00, 1'b0, ta);
        push(0, 8'h99, 1'b0, tb);
        goto(ta + 705);
        check("t6_sout_data", longint'(sout[0]), 0);
        #3 rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_rst_sout",  longint'(sout[0]),     1);
        check("t6_rst_level", longint'(level[0]),    0);
        check("t6_rst_busy",  longint'(busy[0]),     0);
        check("t6_rst_ready", longint'(tx_ready[0]), 1);
        #16 rst = 1'b0;
        goto(ta + 2000);
        check("t6_idle_after", longint'(busy[0]), 0);
        push(0, 8'h81, 1'b0, ta);
        goto(ta + 15);
        check("t6_new_start", longint'(sout[0]), 0);
        goto(ta + 1605);
        check("t6_new_done", longint'(done[0]), 1);
        goto(ta + 1700);
        check("final_drained", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
